stream_mux_rr: RTL
==================

Name: stream_mux_rr

Overview:
- Parametrised N-to-1 data multiplexer and successor to the combinational 4-bit mux tree.
- Supports a generic data width and channel count, with per-channel valid/ready handshakes.
- Has two selection modes: fixed select, or round-robin arbitration.
- Has a single registered output stage. Sits between multiple producer channels and one consumer.

Parameters:
WIDTH, 4, data bits per channel
N, 4, number of input channels (N >= 2)
SELW, $clog2(N), select/channel-index width (derived; do not override)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_data  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  N  per-channel valid
in_ready  output  N  per-channel ready (combinational)
mode  input  1  0 = fixed select via sel; 1 = round-robin
sel  input  SELW  channel index used when mode = 0
out_data  output  WIDTH  registered selected data
out_chan  output  SELW  registered index of the channel that supplied out_data
out_valid  output  1  output holds valid data
out_ready  input  1  consumer ready

Behaviour:
- Clock and reset: single clock, clk. reset is asynchronous and active-high.
- Reset values:
  - out_valid = 0, out_data = 0, out_chan = 0.
  - Round-robin pointer rr_ptr = 0.
  - in_ready = 0 throughout reset.
- Load enable: load = !out_valid || out_ready. The output register accepts a new beat only when load = 1.
- Grant, fixed mode (mode = 0):
  - gnt = sel.
  - Transfer on channel gnt when load && in_valid[gnt].
  - sel values >= N: no grant and all in_ready = 0.
- Grant, round-robin mode (mode = 1):
  - gnt = first i with in_valid[i] = 1, scanning rr_ptr, rr_ptr+1, ..., wrapping modulo N.
  - If no in_valid bit is set, there is no grant.
- in_ready:
  - in_ready[i] = load && grant_exists && (i == gnt).
  - At most one in_ready bit is high per cycle.
- Transfer (in_valid[gnt] && in_ready[gnt]) on a rising edge:
  - out_data <= selected channel data.
  - out_chan <= gnt.
  - out_valid <= 1.
  - In mode 1 only: rr_ptr <= (gnt + 1) mod N, wrapping N-1 to 0. rr_ptr does not change in mode 0.
- Drain with no new transfer: if out_valid && out_ready and no transfer occurs, out_valid <= 0. out_data and out_chan keep their values.
- Back-pressure: while out_valid && !out_ready, out_data, out_chan and out_valid hold stable, and all in_ready = 0.
- Simultaneous drain and load: if out_ready = 1 and a new transfer occurs in the same cycle, back-to-back throughput is 1 beat per cycle with no bubble.
- Latency: exactly 1 cycle from an input transfer to out_valid/out_data.
- Fairness: in mode 1, with all channels continuously valid and out_ready = 1, the grant order is 0,1,...,N-1,0,... Each channel gets exactly one beat per N cycles.
- Mode switching: mode and sel are sampled combinationally each cycle. A change affects only the next grant; a beat already in the output register is never altered. rr_ptr keeps its value across mode changes.
- Mid-operation reset: any held beat is discarded, with out_valid low immediately (asynchronously). rr_ptr returns to 0. After deassertion, the first accepted beat follows normal rules.
- Arithmetic: rr_ptr increments modulo N (handles non-power-of-2 N, e.g. N = 3: 2 -> 0). No other arithmetic.

Test Plan:
1. Reset, then fixed mode: WIDTH=4, N=4, mode=0, sel=2, in_data ch2 = 4'hA, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100. Next cycle out_valid=1, out_data=4'hA, out_chan=2.
2. Fixed mode, non-selected valid: sel=1, in_valid=4'b1101 -> in_ready=4'b0000 and out_valid falls to 0 after the current beat drains.
3. Round-robin fairness: mode=1, in_valid=4'b1111, ch0..ch3 data = 1,2,3,4, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3 and out_data 1,2,3,4,1,2,3,4 with no gaps.
4. Round-robin skip and wrap: rr_ptr=3, in_valid=4'b0011 -> gnt=0, then rr_ptr=1. Next grant is ch1 if still valid.
5. Back-pressure: out_valid=1 with out_data=4'h5, out_ready=0 for 3 cycles while inputs toggle -> out_data stays 4'h5 and in_ready=0. Raising out_ready=1 gives drain plus reload in the same cycle.
6. Async reset mid-stream: assert reset between clock edges with out_valid=1 -> out_valid=0, out_data=0 and out_chan=0 immediately. After release in mode 1 with all channels valid, the first grant is ch0.

Source files
------------

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-to-1 stream multiplexer with a single registered output stage.
// Selection is either a fixed channel index (mode = 0) or round-robin
// arbitration among valid channels (mode = 1).
//
// Handshake semantics: a beat moves across an interface on a rising clk edge
// exactly when valid and ready are both high there. A producer holds data and
// valid stable until it sees ready; ready may depend combinationally on valid
// (in_ready is derived from in_valid, mode, sel and the output-stage state),
// but valid never depends on ready.
module stream_mux_rr #(
  parameter int  WIDTH = 4,
  parameter int  N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [SELW-1:0]  rr_ptr;
  logic             load;
  logic             fix_ok;
  logic             rr_ok;
  logic [SELW-1:0]  rr_gnt;
  logic             grant_exists;
  logic [SELW-1:0]  gnt;
  logic [WIDTH-1:0] gnt_data;
  logic             transfer;

  // The output register can take a beat when it is empty or being drained.
  assign load = !out_valid || out_ready;

  // Fixed-mode grant: sel must name an existing channel that is presenting data.
  always_comb begin
    fix_ok = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (SELW'(i) == sel && in_valid[i]) fix_ok = 1'b1;
    end
  end

  // Round-robin grant: valid channel nearest to rr_ptr, counting upward with wrap.
  always_comb begin
    int d;
    int best_d;
    rr_ok  = 1'b0;
    rr_gnt = '0;
    d      = 0;
    best_d = N;
    for (int i = 0; i < N; i++) begin
      if (i >= int'(rr_ptr)) d = i - int'(rr_ptr);
      else                   d = i + N - int'(rr_ptr);
      if (in_valid[i] && d < best_d) begin
        best_d = d;
        rr_ok  = 1'b1;
        rr_gnt = SELW'(i);
      end
    end
  end

  assign grant_exists = mode ? rr_ok : fix_ok;
  assign gnt          = mode ? rr_gnt : sel;
  // Nothing is accepted while reset is asserted, even though load reads high then.
  assign transfer     = !reset && load && grant_exists;

  // Per-channel ready (one-hot at most) and the granted channel's data.
  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (SELW'(i) == gnt) begin
        in_ready[i] = transfer;
        gnt_data    = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register: load on transfer, clear valid on drain, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_chan  <= gnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Round-robin pointer: moves past the winner only on round-robin transfers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (transfer && mode) begin
      if (int'(gnt) == N - 1) rr_ptr <= '0;
      else                    rr_ptr <= gnt + SELW'(1);
    end
  end

endmodule
